// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one single-port synchronous RAM between CPU and DMA.
// Fixed CPU priority, with a streak counter that bounds DMA starvation.
module ram_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MAX_CPU_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  owner_dma
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

    state_e                state_q, state_d;
    logic [3:0]            streak_q, streak_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic any_req;
    logic grant;
    logic grant_dma;
    logic streak_sat;

    assign any_req    = cpu_req | dma_req;
    assign streak_sat = (streak_q == STREAK_MAX);
    assign grant      = (state_q == ST_IDLE) & any_req;
    // DMA wins when alone, or when the CPU has used up its contested streak
    assign grant_dma  = dma_req & (~cpu_req | streak_sat);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant capture and streak bookkeeping
    always_comb begin
        streak_d = streak_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (grant) begin
            owner_d = grant_dma;
            if (grant_dma) begin
                we_d     = dma_we;
                addr_d   = dma_addr;
                wdata_d  = dma_wdata;
                streak_d = 4'd0;
            end else begin
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                if (dma_req && !streak_sat) begin
                    streak_d = streak_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Outputs decoded from state so reset clears them without waiting an edge
    always_comb begin
        ram_we    = 1'b0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        cpu_rdata = '0;
        dma_rdata = '0;
        unique case (state_q)
            ST_ACCESS: ram_we = we_q;
            ST_RESP: begin
                if (owner_q) begin
                    dma_ack   = 1'b1;
                    dma_rdata = ram_rdata;
                end else begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner_dma = owner_q;

endmodule
